// File: rtl/sc_ctrl_pkg.sv
// Shared encodings for the sc_controller sequencer: state codes, opcodes and strobe bundle.
// Reused by the datapath and testbench.
package sc_ctrl_pkg;

  typedef enum logic [2:0] {
    S_RST   = 3'd0,
    S_FETCH = 3'd1,
    S_DEC   = 3'd2,
    S_LDA   = 3'd3,
    S_STA   = 3'd4,
    S_ADD   = 3'd5,
    S_JMP   = 3'd6,
    S_HALT  = 3'd7
  } sc_state_e;

  localparam logic [1:0] OP_LDA = 2'b00;
  localparam logic [1:0] OP_STA = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;
  localparam logic [1:0] OP_JMP = 2'b11;

  typedef struct packed {
    logic pass;
    logic add;
    logic ld_ac;
    logic ld_ir;
    logic inc_pc;
    logic ld_pc;
    logic ir_on_adr;
    logic pc_on_adr;
    logic alu_on_bus;
    logic rd_mem;
    logic wr_mem;
  } sc_strobe_t;

  // Moore decode: the strobe set is a pure function of the state.
  function automatic sc_strobe_t sc_decode(input sc_state_e st);
    sc_strobe_t s;
    s = '0;
    case (st)
      S_FETCH: begin
        s.pc_on_adr = 1'b1;
        s.rd_mem    = 1'b1;
        s.ld_ir     = 1'b1;
        s.inc_pc    = 1'b1;
      end
      S_LDA: begin
        s.ir_on_adr = 1'b1;
        s.rd_mem    = 1'b1;
        s.ld_ac     = 1'b1;
      end
      S_STA: begin
        s.ir_on_adr = 1'b1;
        s.pass      = 1'b1;
        s.wr_mem    = 1'b1;
      end
      S_ADD: begin
        s.add        = 1'b1;
        s.alu_on_bus = 1'b1;
        s.ld_ac      = 1'b1;
      end
      S_JMP:   s.ld_pc = 1'b1;
      default: s = '0;
    endcase
    return s;
  endfunction

  function automatic logic sc_is_mem(input sc_state_e st);
    return (st == S_FETCH) || (st == S_LDA) || (st == S_STA);
  endfunction

endpackage

// File: rtl/sc_wait_timer.sv
// Down-counting wait-state timer: reload on load, count down on dec, expired at zero.
module sc_wait_timer #(
  parameter int WAIT_MAX = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic dec,
  output logic expired
);

  localparam int W = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
  // Reloading with WAIT_MAX-1 makes the counter hit zero in the WAIT_MAX-th cycle of a state.
  localparam logic [W-1:0] RELOAD = W'(WAIT_MAX - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = RELOAD;
    else if (dec && (cnt_q != '0))
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= RELOAD;
    else     cnt_q <= cnt_d;
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/sc_controller.sv
// Multi-cycle sequencer for the 8-bit accumulator / 6-bit address datapath.
// Optional memory wait states and timeout enabled by defining SC_MEM_WAIT_EN.
module sc_controller
  import sc_ctrl_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int WAIT_MAX = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       opcode,
  input  logic             mem_ready,
  output logic             pass,
  output logic             add,
  output logic             ldAc,
  output logic             ldIr,
  output logic             incPc,
  output logic             ldPc,
  output logic             irOnAdr,
  output logic             pcOnAdr,
  output logic             aluOnBus,
  output logic             rdMem,
  output logic             wrMem,
  output logic [CNT_W-1:0] instr_cnt,
  output logic             err
);

  sc_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             hold;
  logic             gate;
  logic             tmr_expired;
  sc_strobe_t       stb;

`ifdef SC_MEM_WAIT_EN
  // A memory state stalls until mem_ready; loads that commit data are held off until then.
  assign hold = sc_is_mem(state_q) && !mem_ready;
  assign gate = !sc_is_mem(state_q) || mem_ready;

  sc_wait_timer #(
    .WAIT_MAX(WAIT_MAX)
  ) u_wait_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (!hold),
    .dec    (hold),
    .expired(tmr_expired)
  );
`else
  logic unused_mem_ready;
  localparam int unused_wait_max = WAIT_MAX;
  assign unused_mem_ready = mem_ready;
  assign hold        = 1'b0;
  assign gate        = 1'b1;
  assign tmr_expired = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      S_RST:   state_d = S_FETCH;
      S_FETCH: state_d = S_DEC;
      S_DEC: begin
        case (opcode)
          OP_LDA:  state_d = S_LDA;
          OP_STA:  state_d = S_STA;
          OP_ADD:  state_d = S_ADD;
          default: state_d = S_JMP;
        endcase
      end
      S_LDA, S_STA, S_ADD, S_JMP: begin
        state_d = S_FETCH;
        cnt_d   = cnt_q + 1'b1;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_RST;
    endcase
    // A stalled memory state neither advances nor retires; timeout parks in S_HALT.
    if (hold) begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (tmr_expired) begin
        state_d = S_HALT;
        err_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_RST;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    stb        = sc_decode(state_q);
    stb.ld_ir  = stb.ld_ir  & gate;
    stb.ld_ac  = stb.ld_ac  & gate;
    stb.inc_pc = stb.inc_pc & gate;
  end

  assign pass      = stb.pass;
  assign add       = stb.add;
  assign ldAc      = stb.ld_ac;
  assign ldIr      = stb.ld_ir;
  assign incPc     = stb.inc_pc;
  assign ldPc      = stb.ld_pc;
  assign irOnAdr   = stb.ir_on_adr;
  assign pcOnAdr   = stb.pc_on_adr;
  assign aluOnBus  = stb.alu_on_bus;
  assign rdMem     = stb.rd_mem;
  assign wrMem     = stb.wr_mem;
  assign instr_cnt = cnt_q;
  assign err       = err_q;

endmodule
